// File: rtl/mma_job_sched.sv
// mma_job_sched: FIFO-fed job scheduler driving a single matrix-multiply engine.
// Define MMA_SCHED_TIMEOUT_EN to enable the BUSY watchdog and stale-result draining.
module mma_job_sched #(
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned QDEPTH         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [ID_WIDTH-1:0] job_id,
  input  logic                job_16bits_ia,
  output logic                mma_calc_start,
  output logic                mma_cfg_16bits_ia,
  input  logic                mma_sa_ready,
  input  logic                mma_wb_valid,
  output logic                mma_wb_ready,
  input  logic [1:0]          mma_err_code,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_WIDTH-1:0] rsp_id,
  output logic [1:0]          rsp_err,
  output logic                sched_busy
);

  localparam int unsigned PtrW = $clog2(QDEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StBusy, StResp} state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH:0]   mem_q [QDEPTH];
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [CntW-1:0]     count_q;
  logic                push, pop, empty;
  logic [ID_WIDTH-1:0] cur_id_q, rsp_id_q;
  logic                cur_16b_q;
  logic [1:0]          rsp_err_q, rsp_err_d;
  logic                rsp_load;
  logic                stale, timeout_hit;

  assign empty             = (count_q == '0);
  assign job_ready         = (count_q != CntW'(QDEPTH));
  assign push              = job_valid && job_ready;
  assign mma_wb_ready      = (state_q == StBusy) || stale;
  assign mma_cfg_16bits_ia = cur_16b_q;
  assign rsp_id            = rsp_id_q;
  assign rsp_err           = rsp_err_q;
  assign sched_busy        = !empty || (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {job_id, job_16bits_ia};
    end
  end

  always_comb begin
    state_d        = state_q;
    pop            = 1'b0;
    rsp_load       = 1'b0;
    rsp_err_d      = mma_err_code;
    mma_calc_start = 1'b0;
    rsp_valid      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && mma_sa_ready && !stale) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        mma_calc_start = 1'b1;
        state_d        = StBusy;
      end
      StBusy: begin
        if (mma_wb_valid && mma_wb_ready) begin
          rsp_load = 1'b1;
          state_d  = StResp;
        end else if (timeout_hit) begin
          rsp_load  = 1'b1;
          rsp_err_d = 2'b11;
          state_d   = StResp;
        end
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      cur_id_q  <= '0;
      cur_16b_q <= 1'b0;
      rsp_id_q  <= '0;
      rsp_err_q <= '0;
    end else begin
      state_q <= state_d;
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
      if (pop) begin
        {cur_id_q, cur_16b_q} <= mem_q[rptr_q];
      end
      if (rsp_load) begin
        rsp_id_q  <= cur_id_q;
        rsp_err_q <= rsp_err_d;
      end
    end
  end

`ifdef MMA_SCHED_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES);

  logic [WdW-1:0] wd_q;
  logic           stale_q;

  assign stale       = stale_q;
  assign timeout_hit = (state_q == StBusy) && (wd_q == WdW'(TIMEOUT_CYCLES - 1));

  // A timed-out job leaves its result owed by the MMA; swallow it before issuing again.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_q    <= '0;
      stale_q <= 1'b0;
    end else begin
      if (state_q == StStart) begin
        wd_q <= '0;
      end else if (state_q == StBusy) begin
        wd_q <= wd_q + WdW'(1);
      end
      if (timeout_hit && !mma_wb_valid) begin
        stale_q <= 1'b1;
      end else if (stale_q && mma_wb_valid) begin
        stale_q <= 1'b0;
      end
    end
  end
`else
  assign stale       = 1'b0;
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mma_job_sched.sv
// Directed self-checking bench for mma_job_sched with a behavioural MMA responder
// and a scoreboard of expected completions.
module tb_mma_job_sched;

  localparam int unsigned IDW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           job_valid = 1'b0;
  logic           job_ready;
  logic [IDW-1:0] job_id = '0;
  logic           job_16bits_ia = 1'b0;
  logic           mma_calc_start;
  logic           mma_cfg_16bits_ia;
  logic           mma_sa_ready = 1'b1;
  logic           mma_wb_valid = 1'b0;
  logic           mma_wb_ready;
  logic [1:0]     mma_err_code = 2'b00;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [IDW-1:0] rsp_id;
  logic [1:0]     rsp_err;
  logic           sched_busy;

  int n_checks = 0;
  int n_errors = 0;
  int rsp_count = 0;
  int exp_rsps = 0;
  int start_cnt = 0;

  // MMA model controls
  int       mma_lat = 10;
  logic [1:0] mma_err = 2'b00;
  bit       mma_mute = 1'b0;
  bit       force_wb = 1'b0;
  int       cd = -1;
  bit       wb_hs = 1'b0;

  logic [IDW+1:0] sb[$];
  logic [IDW+1:0] e;

  mma_job_sched #(
    .ID_WIDTH      (IDW),
    .QDEPTH        (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .job_valid        (job_valid),
    .job_ready        (job_ready),
    .job_id           (job_id),
    .job_16bits_ia    (job_16bits_ia),
    .mma_calc_start   (mma_calc_start),
    .mma_cfg_16bits_ia(mma_cfg_16bits_ia),
    .mma_sa_ready     (mma_sa_ready),
    .mma_wb_valid     (mma_wb_valid),
    .mma_wb_ready     (mma_wb_ready),
    .mma_err_code     (mma_err_code),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_id           (rsp_id),
    .rsp_err          (rsp_err),
    .sched_busy       (sched_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // MMA responder: raises wb_valid mma_lat cycles after a start, holds it until taken.
  always @(negedge clk) begin
    if (!rst_n) begin
      cd           = -1;
      mma_wb_valid = 1'b0;
      wb_hs        = 1'b0;
    end else begin
      if (wb_hs) mma_wb_valid = 1'b0;
      if (mma_calc_start) begin
        start_cnt++;
        cd = mma_lat;
      end else if (cd > 0) begin
        cd--;
      end
      if (cd == 0) begin
        if (!mma_mute) begin
          mma_wb_valid = 1'b1;
          mma_err_code = mma_err;
        end
        cd = -1;
      end
      if (force_wb) begin
        mma_wb_valid = 1'b1;
        mma_err_code = mma_err;
        force_wb     = 1'b0;
      end
      wb_hs = mma_wb_valid && mma_wb_ready;
    end
  end

  // Completion monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      chk("rsp_expected_pending", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_id", rsp_id, e[IDW+1:2]);
        chk("rsp_err", rsp_err, e[1:0]);
      end
      rsp_count++;
    end
  end

  task automatic push_job(input logic [IDW-1:0] id, input logic b16, input logic [1:0] err,
                          input bit expect_rsp);
    int n = 0;
    job_valid     = 1'b1;
    job_id        = id;
    job_16bits_ia = b16;
    @(negedge clk);
    while (!job_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept", job_ready, 1);
    @(posedge clk); #1;
    job_valid = 1'b0;
    if (expect_rsp) begin
      sb.push_back({id, err});
      exp_rsps++;
    end
  endtask

  task automatic wait_rsps(input int max_cyc);
    int n = 0;
    while (rsp_count < exp_rsps && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_count_reached", rsp_count, exp_rsps);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int max_cyc);
    int n = 0;
    while (!rsp_valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("wait_rsp_valid", rsp_valid, 1);
  endtask

  initial begin
    int n;
    int s;
    int vcnt;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_job_ready", job_ready, 1);
    chk("rst_calc_start", mma_calc_start, 0);
    chk("rst_wb_ready", mma_wb_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", sched_busy, 0);
    chk("rst_cfg", mma_cfg_16bits_ia, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single job, 16-bit mode, start at T+2
    mma_lat = 10;
    mma_err = 2'b00;
    push_job(4'd5, 1'b1, 2'b00, 1'b1);
    @(negedge clk);
    chk("t1_no_early_start", mma_calc_start, 0);
    @(negedge clk);
    chk("t1_start_t2", mma_calc_start, 1);
    n = 0;
    while (!rsp_valid && n < 40) begin
      chk("t1_cfg_held", mma_cfg_16bits_ia, 1);
      @(negedge clk);
      n++;
    end
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_cfg_in_resp", mma_cfg_16bits_ia, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_rsp_dropped", rsp_valid, 0);
    chk("t1_idle_busy", sched_busy, 0);
    chk("t1_one_start", start_cnt, 1);
    @(posedge clk); #1;

    // Five back-to-back jobs into a 4-deep queue with a slow MMA
    mma_lat = 30;
    for (int k = 1; k <= 5; k++) push_job(IDW'(k), 1'b0, 2'b00, 1'b1);
    job_valid = 1'b1;
    job_id    = 4'd6;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t2_full_blocks", job_ready, 0);
      chk("t2_busy", sched_busy, 1);
    end
    @(posedge clk); #1;
    job_valid = 1'b0;
    wait_rsps(400);
    @(negedge clk);
    chk("t2_idle_busy", sched_busy, 0);
    chk("t2_start_count", start_cnt, 6);
    @(posedge clk); #1;

    // Response backpressure: rsp held stable, no new start
    rsp_ready = 1'b0;
    mma_lat   = 3;
    mma_err   = 2'b01;
    push_job(4'd9, 1'b1, 2'b01, 1'b1);
    push_job(4'd10, 1'b0, 2'b10, 1'b1);
    wait_valid(40);
    s = start_cnt;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t3_valid_held", rsp_valid, 1);
      chk("t3_id_held", rsp_id, 9);
      chk("t3_err_held", rsp_err, 2'b01);
      chk("t3_no_start", mma_calc_start, 0);
    end
    chk("t3_start_count_held", start_cnt, s);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    mma_err   = 2'b10;
    wait_rsps(60);

    // MMA not ready: start follows one cycle after sa_ready rises
    mma_err      = 2'b00;
    mma_lat      = 5;
    mma_sa_ready = 1'b0;
    push_job(4'd3, 1'b0, 2'b00, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t4_blocked", mma_calc_start, 0);
    end
    @(posedge clk); #1;
    mma_sa_ready = 1'b1;
    @(negedge clk);
    chk("t4_not_same_cycle", mma_calc_start, 0);
    @(negedge clk);
    chk("t4_start_next", mma_calc_start, 1);
    wait_rsps(60);

`ifdef MMA_SCHED_TIMEOUT_EN
    // Watchdog: silent MMA, error 11 after 16 BUSY cycles, then drain of the late result
    mma_mute = 1'b1;
    push_job(4'd12, 1'b1, 2'b11, 1'b1);
    n = 0;
    @(negedge clk);
    while (!mma_calc_start && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("to_start", mma_calc_start, 1);
    repeat (16) @(negedge clk);
    chk("to_not_yet", rsp_valid, 0);
    @(negedge clk);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 2'b11);
    @(posedge clk); #1;
    push_job(4'd13, 1'b0, 2'b00, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("to_stale_blocks", mma_calc_start, 0);
      chk("to_stale_wb_ready", mma_wb_ready, 1);
    end
    @(posedge clk); #1;
    mma_mute = 1'b0;
    mma_err  = 2'b00;
    force_wb = 1'b1;
    wait_rsps(60);
`endif

    // Reset in BUSY with two jobs queued discards everything
    mma_lat = 20;
    push_job(4'd7, 1'b1, 2'b00, 1'b0);
    push_job(4'd8, 1'b0, 2'b00, 1'b0);
    push_job(4'd11, 1'b1, 2'b00, 1'b0);
    @(negedge clk);
    chk("rst2_pre_busy", sched_busy, 1);
    chk("rst2_pre_in_busy", mma_wb_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    exp_rsps = rsp_count;
    sb.delete();
    @(negedge clk);
    chk("rst2_job_ready", job_ready, 1);
    chk("rst2_calc_start", mma_calc_start, 0);
    chk("rst2_wb_ready", mma_wb_ready, 0);
    chk("rst2_rsp_valid", rsp_valid, 0);
    chk("rst2_busy", sched_busy, 0);
    chk("rst2_cfg", mma_cfg_16bits_ia, 0);
    vcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rsp_valid || mma_calc_start) vcnt++;
    end
    chk("rst2_no_activity", vcnt, 0);
    chk("rst2_no_rsp", rsp_count, exp_rsps);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish before 500000");
    $fatal(1, "global timeout");
  end

endmodule
